divider_arbiter: RTL

Shares one `ReciprocalDivider` instance (AXI-stream dividend/divisor/dout channels) among `NUM_REQ` requesters, e.g. the per-vertex perspective-divide stages of the pipeline. The block picks requesters round-robin and keeps one operation in flight. It issues the operands to the divider, captures the quotient and returns it to the granted requester over a valid/ready response channel. Divide-by-zero never reaches the divider; the block answers it locally with a saturated quotient.

---
 rtl/reciprocal_divider_params.sv | 23 ++
 rtl/round_robin_picker.sv | 32 +++
 rtl/divider_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/reciprocal_divider_params.sv
// Shared types and constants for the reciprocal divider arbiter.
// Also holds the default operand widths.
package reciprocal_divider_params;

  localparam int DIVIDEND_AND_QUOTIENT_WIDTH = 32;
  localparam int DIVISOR_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESPOND
  } divider_arbiter_state_t;

  localparam logic [DIVIDEND_AND_QUOTIENT_WIDTH-1:0]
    QUOTIENT_SAT_MAX =
      {1'b0, {(DIVIDEND_AND_QUOTIENT_WIDTH-1){1'b1}}};

  localparam logic [DIVIDEND_AND_QUOTIENT_WIDTH-1:0]
    QUOTIENT_SAT_MIN =
      {1'b1, {(DIVIDEND_AND_QUOTIENT_WIDTH-1){1'b0}}};

endpackage

// File: rtl/round_robin_picker.sv
// Combinational round-robin pick: first valid bit
// at or above ptr_i, wrapping around.
module round_robin_picker #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_oh_o,
  output logic [IW-1:0] grant_idx_o,
  output logic          any_o
);

  int k;

  // Scan N positions starting at the pointer.
  always_comb begin
    grant_oh_o  = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    k           = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr_i) + i) % N;
      if (!any_o && req_valid_i[k]) begin
        any_o         = 1'b1;
        grant_oh_o[k] = 1'b1;
        grant_idx_o   = IW'(k);
      end
    end
  end

endmodule

// File: rtl/divider_arbiter.sv
// Round-robin sharing of one AXI-stream divider.
// One operation in flight; divide-by-zero answered locally.
module divider_arbiter
  import reciprocal_divider_params::*;
#(
  parameter int NUM_REQ = 4,
  parameter int QW = DIVIDEND_AND_QUOTIENT_WIDTH,
  parameter int DW = DIVISOR_WIDTH
) (
  input  logic                        aclk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0][QW-1:0]  req_dividend,
  input  logic [NUM_REQ-1:0][DW-1:0]  req_divisor,
  output logic [NUM_REQ-1:0]          rsp_valid,
  input  logic [NUM_REQ-1:0]          rsp_ready,
  output logic [QW-1:0]               rsp_quotient,
  output logic                        rsp_div_by_zero,
  output logic                        div_dividend_tvalid,
  input  logic                        div_dividend_tready,
  output logic [QW-1:0]               div_dividend_tdata,
  output logic                        div_divisor_tvalid,
  input  logic                        div_divisor_tready,
  output logic [DW-1:0]               div_divisor_tdata,
  input  logic                        div_dout_tvalid,
  output logic                        div_dout_tready,
  input  logic [QW-1:0]               div_dout_tdata,
  output logic                        busy
);

  localparam int IW = $clog2(NUM_REQ);

  localparam logic [QW-1:0] SAT_MAX =
    {1'b0, {(QW-1){1'b1}}};
  localparam logic [QW-1:0] SAT_MIN =
    {1'b1, {(QW-1){1'b0}}};

  divider_arbiter_state_t state_q, state_d;

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [QW-1:0] dvd_q, dvd_d;
  logic [DW-1:0] dvs_q, dvs_d;
  logic [QW-1:0] quot_q, quot_d;
  logic          dbz_q, dbz_d;
  logic          dvd_sent_q, dvd_sent_d;
  logic          dvs_sent_q, dvs_sent_d;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic [QW-1:0]      sel_dvd;
  logic [DW-1:0]      sel_dvs;

  round_robin_picker #(
    .N (NUM_REQ)
  ) u_pick (
    .req_valid_i (req_valid),
    .ptr_i       (ptr_q),
    .grant_oh_o  (pick_oh),
    .grant_idx_o (pick_idx),
    .any_o       (pick_any)
  );

  assign sel_dvd = req_dividend[pick_idx];
  assign sel_dvs = req_divisor[pick_idx];

  assign rsp_quotient       = quot_q;
  assign rsp_div_by_zero    = dbz_q;
  assign div_dividend_tdata = dvd_q;
  assign div_divisor_tdata  = dvs_q;
  assign busy               = (state_q != ST_IDLE);

  // Next-state and handshake outputs for the four phases.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    quot_d     = quot_q;
    dbz_d      = dbz_q;
    dvd_sent_d = dvd_sent_q;
    dvs_sent_d = dvs_sent_q;

    req_ready           = '0;
    rsp_valid           = '0;
    div_dividend_tvalid = 1'b0;
    div_divisor_tvalid  = 1'b0;
    div_dout_tready     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_any && !reset) begin
          req_ready  = pick_oh;
          gnt_d      = pick_idx;
          dvd_d      = sel_dvd;
          dvs_d      = sel_dvs;
          dvd_sent_d = 1'b0;
          dvs_sent_d = 1'b0;
          if (sel_dvs == '0) begin
            dbz_d   = 1'b1;
            quot_d  = sel_dvd[QW-1] ? SAT_MIN
                                    : SAT_MAX;
            state_d = ST_RESPOND;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        div_dividend_tvalid = !dvd_sent_q;
        div_divisor_tvalid  = !dvs_sent_q;
        if (!dvd_sent_q && div_dividend_tready)
          dvd_sent_d = 1'b1;
        if (!dvs_sent_q && div_divisor_tready)
          dvs_sent_d = 1'b1;
        if (dvd_sent_d && dvs_sent_d)
          state_d = ST_WAIT;
      end

      ST_WAIT: begin
        div_dout_tready = 1'b1;
        if (div_dout_tvalid) begin
          quot_d  = div_dout_tdata;
          dbz_d   = 1'b0;
          state_d = ST_RESPOND;
        end
      end

      ST_RESPOND: begin
        rsp_valid[gnt_q] = 1'b1;
        if (rsp_ready[gnt_q]) begin
          state_d = ST_IDLE;
          ptr_d   = (gnt_q == IW'(NUM_REQ-1))
                    ? '0 : gnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State, operand latches and sent flags.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      quot_q     <= '0;
      dbz_q      <= 1'b0;
      dvd_sent_q <= 1'b0;
      dvs_sent_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      quot_q     <= quot_d;
      dbz_q      <= dbz_d;
      dvd_sent_q <= dvd_sent_d;
      dvs_sent_q <= dvs_sent_d;
    end
  end

endmodule
